// File: rtl/cpu_trace_buffer.sv
// On-chip execution trace capture for the turtle CPU.
// A circular buffer holds {cycle stamp, pc, instruction, acc} for each retired
// step. It has a pc-match trigger with programmable post-trigger depth, sticky
// halt-loop detection, and a synchronous indexed readout port (index 0 = oldest).
module cpu_trace_buffer #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 16,
  parameter int ACC_WIDTH   = 8,
  parameter int DEPTH       = 64,
  parameter int CYC_WIDTH   = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          step,
  input  logic [PC_WIDTH-1:0]                           pc,
  input  logic [INSTR_WIDTH-1:0]                        instruction,
  input  logic [ACC_WIDTH-1:0]                          acc,
  input  logic                                          arm,
  input  logic                                          trig_en,
  input  logic [PC_WIDTH-1:0]                           trig_pc,
  input  logic [$clog2(DEPTH):0]                        post_count,
  input  logic                                          rd_en,
  input  logic [$clog2(DEPTH)-1:0]                      rd_idx,
  output logic                                          rd_valid,
  output logic [CYC_WIDTH+PC_WIDTH+INSTR_WIDTH+ACC_WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0]                        count,
  output logic [1:0]                                    state,
  output logic                                          triggered,
  output logic                                          halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = CYC_WIDTH + PC_WIDTH + INSTR_WIDTH + ACC_WIDTH;
  localparam int RW = $clog2(HALT_REPEAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         remain_q, remain_d;
  logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
  logic [RW-1:0]         run_q, run_d;
  logic [PC_WIDTH-1:0]   prev_pc_q, prev_pc_d;
  logic                  prev_vld_q, prev_vld_d;
  logic                  triggered_q, triggered_d;
  logic                  halted_q, halted_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [EW-1:0]         rd_data_q, rd_data_d;

  logic                  wr_en;
  logic                  rd_hit;
  logic [AW-1:0]         rd_addr;
  logic [EW-1:0]         mem [DEPTH];

  // Capture control, trigger/post-trigger sequencing, halt detection and read lookup.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    remain_d    = remain_q;
    run_d       = run_q;
    prev_pc_d   = prev_pc_q;
    prev_vld_d  = prev_vld_q;
    triggered_d = triggered_q;
    halted_d    = halted_q;
    wr_en       = 1'b0;
    cyc_d       = step ? cyc_q + CYC_WIDTH'(1) : cyc_q;

    if (arm) begin
      // Arm wins over a same-cycle step: that step is dropped, not captured.
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      remain_d    = '0;
      run_d       = '0;
      prev_vld_d  = 1'b0;
      triggered_d = 1'b0;
      halted_d    = 1'b0;
    end else if (step && (state_q == S_ARMED || state_q == S_POST)) begin
      wr_en    = reset_n;
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);

      // Run length of consecutive identical pcs; saturates at the halt threshold.
      if (prev_vld_q && pc == prev_pc_q) begin
        if (run_q < RW'(HALT_REPEAT - 1)) run_d = run_q + RW'(1);
      end else begin
        run_d = '0;
      end
      prev_pc_d  = pc;
      prev_vld_d = 1'b1;
      if (run_d == RW'(HALT_REPEAT - 1)) halted_d = 1'b1;

      if (state_q == S_ARMED) begin
        if (trig_en && pc == trig_pc) begin
          triggered_d = 1'b1;
          if (post_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_POST;
            remain_d = post_count;
          end
        end
      end else begin
        remain_d = remain_q - CW'(1);
        if (remain_q == CW'(1)) state_d = S_DONE;
      end
    end

    // Index 0 maps to the oldest held entry; read returns the pre-write snapshot.
    rd_addr    = wr_ptr_q - count_q[AW-1:0] + rd_idx;
    rd_hit     = rd_en && ({1'b0, rd_idx} < count_q);
    rd_valid_d = rd_hit;
    rd_data_d  = rd_hit ? mem[rd_addr] : '0;
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      remain_q    <= '0;
      cyc_q       <= '0;
      run_q       <= '0;
      prev_pc_q   <= '0;
      prev_vld_q  <= 1'b0;
      triggered_q <= 1'b0;
      halted_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      remain_q    <= remain_d;
      cyc_q       <= cyc_d;
      run_q       <= run_d;
      prev_pc_q   <= prev_pc_d;
      prev_vld_q  <= prev_vld_d;
      triggered_q <= triggered_d;
      halted_q    <= halted_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Trace storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates which entries are readable.
    if (wr_en) mem[wr_ptr_q] <= {cyc_q, pc, instruction, acc};
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign count     = count_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer. Reads push their expected response into
// a scoreboard queue; a monitor pops and compares on the cycle rd_valid is due.
module tb_cpu_trace_buffer;

  localparam int PW = 10, IW = 16, AWD = 8, DEPTH = 64, CYW = 16, HR = 4;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CYW + PW + IW + AWD;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            step, arm, trig_en, rd_en;
  logic [PW-1:0]   pc, trig_pc;
  logic [IW-1:0]   instruction;
  logic [AWD-1:0]  acc;
  logic [AW:0]     post_count;
  logic [AW-1:0]   rd_idx;
  logic            rd_valid, triggered, halted;
  logic [EW-1:0]   rd_data;
  logic [AW:0]     count;
  logic [1:0]      state;

  typedef struct {
    logic          v;
    logic [EW-1:0] d;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_total = 0;

  cpu_trace_buffer #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .ACC_WIDTH(AWD),
    .DEPTH(DEPTH), .CYC_WIDTH(CYW), .HALT_REPEAT(HR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .step(step), .pc(pc),
    .instruction(instruction), .acc(acc), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_count(post_count), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .state(state),
    .triggered(triggered), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] instr_of(input int p);
    return IW'(16'h1000 + p);
  endfunction

  function automatic logic [AWD-1:0] acc_of(input int p);
    return AWD'(p * 3);
  endfunction

  function automatic logic [EW-1:0] mk(input int cyc, input int p);
    return {CYW'(cyc), PW'(p), instr_of(p), acc_of(p)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic cycle(input logic s, input int p, input logic a, input logic re, input int idx);
    step = s; pc = PW'(p); instruction = instr_of(p); acc = acc_of(p);
    arm = a; rd_en = re; rd_idx = AW'(idx);
    @(posedge clk); #1;
    step = 1'b0; arm = 1'b0; rd_en = 1'b0;
    if (s && reset_n) cyc_total++;
  endtask

  task automatic do_step(input int p);
    cycle(1'b1, p, 1'b0, 1'b0, 0);
  endtask

  task automatic do_arm();
    cycle(1'b0, 0, 1'b1, 1'b0, 0);
  endtask

  task automatic do_read(input int idx, input logic v, input logic [EW-1:0] d, input string name);
    exp_t e;
    e.v = v; e.d = v ? d : '0; e.name = name;
    sb.push_back(e);
    cycle(1'b0, 0, 1'b0, 1'b1, idx);
  endtask

  // Monitor: a response is due on the edge that samples rd_en.
  initial begin : monitor
    logic pend;
    exp_t e;
    forever begin
      @(posedge clk);
      pend = rd_en;
      #2;
      if (pend) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_valid"}, 64'(rd_valid), 64'(e.v));
          check({e.name, "_data"}, 64'(rd_data), 64'(e.d));
        end
      end else if (rd_valid) begin
        check("spurious_rd_valid", 64'(rd_valid), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int base;
    reset_n = 1'b0; step = 1'b0; arm = 1'b0; rd_en = 1'b0; trig_en = 1'b0;
    pc = '0; instruction = '0; acc = '0; trig_pc = '0; post_count = '0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_trig", 64'(triggered), 64'd0);
    check("rst_halt", 64'(halted), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);

    // 10 plain steps; cycle stamps 0..9.
    do_arm();
    check("arm_state", 64'(state), 64'd1);
    for (int k = 0; k < 10; k++) do_step(k);
    check("t1_count", 64'(count), 64'd10);
    check("t1_state", 64'(state), 64'd1);
    do_read(0, 1'b1, mk(0, 0), "t1_idx0");
    do_read(9, 1'b1, mk(9, 9), "t1_idx9");
    do_read(10, 1'b0, '0, "t1_idx10");

    // 100 steps wrap a 64-deep buffer; stamps start at 10.
    do_arm();
    for (int k = 0; k < 100; k++) do_step(k);
    check("t2_count", 64'(count), 64'd64);
    do_read(0, 1'b1, mk(46, 36), "t2_idx0");
    do_read(63, 1'b1, mk(109, 99), "t2_idx63");

    // Trigger at pc=20 with 5 post entries; stamps start at 110.
    trig_en = 1'b1; trig_pc = 10'd20; post_count = 7'd5;
    do_arm();
    for (int k = 0; k <= 30; k++) begin
      do_step(k);
      if (k == 19) check("t3_pre_trig", 64'(triggered), 64'd0);
      if (k == 20) begin
        check("t3_trig", 64'(triggered), 64'd1);
        check("t3_post", 64'(state), 64'd2);
      end
      if (k == 24) check("t3_still_post", 64'(state), 64'd2);
      if (k == 25) check("t3_done", 64'(state), 64'd3);
    end
    check("t3_count", 64'(count), 64'd26);
    do_read(25, 1'b1, mk(135, 25), "t3_last");
    do_read(0, 1'b1, mk(110, 0), "t3_first");
    do_read(26, 1'b0, '0, "t3_beyond");

    // post_count = 0: done on the trigger step itself; stamps start at 141.
    trig_pc = 10'd3; post_count = 7'd0;
    do_arm();
    for (int k = 0; k <= 5; k++) begin
      do_step(k);
      if (k == 3) begin
        check("t4_done", 64'(state), 64'd3);
        check("t4_count", 64'(count), 64'd4);
      end
    end
    check("t4_frozen", 64'(count), 64'd4);
    do_read(3, 1'b1, mk(144, 3), "t4_newest");
    trig_en = 1'b0;

    // Halt loop: pc 5,6,7,7,7,7 -> halted on the 4th pc=7 step.
    do_arm();
    do_step(5); do_step(6);
    for (int k = 1; k <= 4; k++) begin
      do_step(7);
      check($sformatf("t5_halt_after_%0d", k), 64'(halted), (k == 4) ? 64'd1 : 64'd0);
    end
    check("t5_capture_goes_on", 64'(count), 64'd6);
    do_arm();
    check("t5_arm_halt", 64'(halted), 64'd0);
    check("t5_arm_count", 64'(count), 64'd0);

    // Arm plus step in DONE: step dropped, buffer cleared.
    trig_en = 1'b1; trig_pc = 10'd1; post_count = 7'd0;
    do_arm();
    do_step(0); do_step(1);
    check("t6_done", 64'(state), 64'd3);
    cycle(1'b1, 9, 1'b1, 1'b0, 0);
    check("t6_state", 64'(state), 64'd1);
    check("t6_count", 64'(count), 64'd0);
    check("t6_trig_clr", 64'(triggered), 64'd0);
    do_read(0, 1'b0, '0, "t6_idx0");
    trig_en = 1'b0;

    // Reset mid-capture: back to IDLE, counter cleared, no further writes.
    do_step(1); do_step(2);
    reset_n = 1'b0;
    cycle(1'b1, 3, 1'b0, 1'b0, 0);
    reset_n = 1'b1;
    check("t7_rst_state", 64'(state), 64'd0);
    check("t7_rst_count", 64'(count), 64'd0);
    do_step(4); do_step(5);
    check("t7_idle_count", 64'(count), 64'd0);
    do_arm();
    do_step(8);
    base = 2;  // two IDLE steps after reset advanced the stamp counter
    do_read(0, 1'b1, mk(base, 8), "t7_stamp");

    repeat (3) @(posedge clk);
    #3;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised on-chip execution trace capture for the turtle CPU. It replaces ad-hoc per-cycle printing with a hardware circular buffer, so traces are available on the board, not only in simulation. Each retired cycle it records {cycle count, pc, instruction, acc}, supports a pc-match trigger with programmable post-trigger depth, and detects halt loops. It sits beside turtle_cpu_top and taps pc/instruction/acc_out; readout is through a synchronous indexed port.

Parameters:
PC_WIDTH, 10, width of pc tap.
INSTR_WIDTH, 16, width of instruction tap.
ACC_WIDTH, 8, width of accumulator tap.
DEPTH, 64, number of trace entries; power of two, >=4.
CYC_WIDTH, 16, width of per-entry cycle stamp and free-running cycle counter.
HALT_REPEAT, 4, consecutive identical-pc steps that flag a halt.

Ports:
clk  in  1  system clock.
reset_n  in  1  synchronous, active-low reset.
step  in  1  one CPU cycle retired this clk; capture qualifier.
pc  in  PC_WIDTH  pc tap.
instruction  in  INSTR_WIDTH  instruction tap.
acc  in  ACC_WIDTH  accumulator tap.
arm  in  1  pulse: clear buffer and start capture.
trig_en  in  1  enable pc-match trigger.
trig_pc  in  PC_WIDTH  trigger pc value.
post_count  in  $clog2(DEPTH)+1  entries to capture after trigger (0..DEPTH).
rd_en  in  1  read request.
rd_idx  in  $clog2(DEPTH)  index, 0 = oldest valid entry.
rd_valid  out  1  rd_data valid (1 cycle after rd_en).
rd_data  out  CYC_WIDTH+PC_WIDTH+INSTR_WIDTH+ACC_WIDTH  {cyc, pc, instruction, acc}, MSB first.
count  out  $clog2(DEPTH)+1  valid entries held (saturates at DEPTH).
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
triggered  out  1  trigger has fired since arm.
halted  out  1  halt loop detected since arm.

Behaviour:
- Single clock domain; reset_n sampled on posedge clk only. Reset: state=IDLE, count=0, wr_ptr=0, cycle counter=0, triggered=0, halted=0, rd_valid=0, rd_data=0. Memory contents are not reset.
- Cycle counter increments on every step, in any state, wraps modulo 2^CYC_WIDTH; stamp stored is the value before increment.
- IDLE: no capture. arm -> ARMED, clears count/wr_ptr/triggered/halted/halt run counter.
- ARMED: each step writes entry at wr_ptr, wr_ptr++ (wraps at DEPTH, overwriting oldest), count++ saturating at DEPTH. If trig_en and pc==trig_pc on a step: that entry is written, triggered=1; post_count==0 -> DONE, else -> POST with remaining=post_count.
- POST: each step writes entry, remaining--; when remaining reaches 0 after a write -> DONE. Trigger ignored.
- DONE: no capture; buffer frozen. arm -> ARMED (re-arm).
- arm in any state has priority over a same-cycle step: the step is not captured, clear happens, and state=ARMED.
- Halt: in ARMED/POST, run counter counts consecutive steps whose pc equals the previous step's pc; when it reaches HALT_REPEAT-1 (HALT_REPEAT equal pcs), halted=1 (sticky until arm/reset). halted does not stop capture.
- Read: rd_en with rd_idx<count -> next cycle rd_valid=1, rd_data=entry at physical (wr_ptr-count+rd_idx) mod DEPTH. rd_idx>=count -> rd_valid=0, rd_data=0. rd_valid is 0 on cycles without a prior rd_en. Read during capture is allowed; it returns the snapshot at the rd_en cycle (read-before-write on the same physical address).
- Reset mid-capture: returns to IDLE immediately; no further writes.

Test Plan:
- Reset, arm, 10 steps pc=0..9 no trigger -> count=10, state=ARMED, rd_idx=0 gives pc=0 cyc=0, rd_idx=9 gives pc=9 cyc=9, rd_valid one cycle after rd_en.
- DEPTH=64, 100 steps pc=0..99 -> count=64, rd_idx=0 pc=36, rd_idx=63 pc=99 (wrap).
- trig_en, trig_pc=20, post_count=5, pc=0.. -> triggered at pc=20, DONE after pc=25 captured, steps beyond leave count/data unchanged, last entry pc=25.
- post_count=0, trig_pc=3 -> DONE on the pc=3 step, newest entry pc=3.
- pc sequence 5,6,7,7,7,7 with HALT_REPEAT=4 -> halted=1 on the 4th pc=7 step, not before; arm clears halted and count to 0.
- arm asserted on same cycle as a step in DONE -> count=0, state=ARMED, that step not recorded; rd_idx=0 -> rd_valid=0.
